// File: rtl/stream_pkg.sv
// stream_pkg: shared arbiter FSM states and source-index width helper
package stream_pkg;
  typedef enum logic {IDLE, LOCKED} state_t;
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stream_arbiter_if.sv
// stream_arbiter_if: request-side and output-side stream handshake bundle
interface stream_arbiter_if #(parameter int N = 4, parameter int WIDTH = 32);
  localparam int SRC_W = (N > 1) ? $clog2(N) : 1;
  logic [N-1:0]       request_valid;
  logic [N-1:0]       request_ready;
  logic [N*WIDTH-1:0] request_data;
  logic [N-1:0]       request_last;
  logic               output_ready;
  logic               output_valid;
  logic [WIDTH-1:0]   output_data;
  logic               output_last;
  logic [SRC_W-1:0]   output_source;
  modport master (
    output request_valid, request_data, request_last, output_ready,
    input  request_ready, output_valid, output_data, output_last, output_source
  );
  modport slave (
    input  request_valid, request_data, request_last, output_ready,
    output request_ready, output_valid, output_data, output_last, output_source
  );
endinterface

// File: rtl/stream_arbiter_rr_pick.sv
// rr_pick: first set request at or after ptr, wrapping around
module rr_pick #(parameter int N = 4, parameter int SRC_W = 2) (
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] ptr,
  output logic [SRC_W-1:0] idx,
  output logic             any
);
  logic found;
  int j;
  assign any = |req;
  // scan from ptr upward with wrap, keep the first hit
  always_comb begin
    idx = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        idx = SRC_W'(j);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/stream_arbiter.sv
// stream_arbiter: round-robin burst-locked N:1 stream arbiter with registered output
module stream_arbiter import stream_pkg::*; #(
  parameter int N = 4,
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  stream_arbiter_if.slave bus
);
  localparam int SRC_W = src_width(N);
  state_t state;
  logic [SRC_W-1:0] ptr, g, pick;
  logic any, req_xfer;
  rr_pick #(.N(N), .SRC_W(SRC_W)) u_pick (
    .req(bus.request_valid), .ptr(ptr), .idx(pick), .any(any)
  );
  // only the granted requester sees ready, and only when the output slot frees
  always_comb begin
    bus.request_ready = (state == LOCKED && (!bus.output_valid || bus.output_ready)) ? N'(1) << g : '0;
  end
  assign req_xfer = bus.request_valid[g] && bus.request_ready[g];
  // arbitration FSM plus output register; a last beat releases the grant and advances ptr
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      g <= '0;
      bus.output_valid <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (any) begin
          g <= pick;
          state <= LOCKED;
        end
      end else if (req_xfer && bus.request_last[g]) begin
        state <= IDLE;
        ptr <= (g == SRC_W'(N - 1)) ? '0 : g + 1'b1;
      end
      if (req_xfer) begin
        bus.output_valid <= 1'b1;
        bus.output_data <= bus.request_data[g*WIDTH +: WIDTH];
        bus.output_last <= bus.request_last[g];
        bus.output_source <= g;
      end else if (bus.output_valid && bus.output_ready) begin
        bus.output_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_arbiter.sv
// tb_stream_arbiter: directed checks of grant order, bursts, backpressure and reset
module tb_stream_arbiter;
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  stream_arbiter_if #(.N(4), .WIDTH(32)) bus ();
  stream_arbiter #(.N(4), .WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_data(input int i, input logic [31:0] d);
    bus.request_data[i*32 +: 32] = d;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.request_valid = '0;
    bus.request_last = '0;
    bus.output_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_data(i, 32'h10 + i);
    cyc();
    cyc();
    reset = 1'b0;
  endtask
  initial begin
    bus.request_data = '0;
    do_reset();
    chk("rst_ov", bus.output_valid, 0);
    chk("rst_ready", bus.request_ready, 0);
    // scenario 1: requesters 1 and 2, one-beat bursts
    bus.request_valid = 4'b0110;
    bus.request_last = 4'b1111;
    settle();
    chk("s1_idle_ready", bus.request_ready, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("s1_grant_ready", bus.request_ready, (k % 2 == 0) ? 4'b0010 : 4'b0100);
      chk("s1_gap_ov", bus.output_valid, 0);
      cyc();
      chk("s1_ov", bus.output_valid, 1);
      chk("s1_src", bus.output_source, (k % 2 == 0) ? 1 : 2);
      chk("s1_data", bus.output_data, (k % 2 == 0) ? 32'h11 : 32'h12);
      chk("s1_arb_ready", bus.request_ready, 0);
    end
    // scenario 2: 3-beat burst from 0 while 3 waits
    do_reset();
    bus.request_valid = 4'b1001;
    bus.request_last = 4'b1000;
    set_data(0, 32'hA0);
    set_data(3, 32'h33);
    cyc();
    chk("s2_ready", bus.request_ready, 4'b0001);
    cyc();
    chk("s2_b0", bus.output_data, 32'hA0);
    chk("s2_b0_src", bus.output_source, 0);
    chk("s2_b0_last", bus.output_last, 0);
    set_data(0, 32'hA1);
    cyc();
    chk("s2_b1", bus.output_data, 32'hA1);
    chk("s2_b1_src", bus.output_source, 0);
    set_data(0, 32'hA2);
    bus.request_last = 4'b1001;
    cyc();
    chk("s2_b2", bus.output_data, 32'hA2);
    chk("s2_b2_last", bus.output_last, 1);
    bus.request_valid = 4'b1000;
    cyc();
    chk("s2_gap_ov", bus.output_valid, 0);
    chk("s2_r3_ready", bus.request_ready, 4'b1000);
    cyc();
    chk("s2_r3_src", bus.output_source, 3);
    chk("s2_r3_data", bus.output_data, 32'h33);
    bus.request_valid = '0;
    // scenario 3: 5 cycles of output backpressure on requester 2
    do_reset();
    bus.request_valid = 4'b0100;
    set_data(2, 32'hB0);
    cyc();
    chk("s3_ready", bus.request_ready, 4'b0100);
    cyc();
    set_data(2, 32'hB1);
    bus.output_ready = 1'b0;
    settle();
    chk("s3_stall_ready", bus.request_ready, 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("s3_hold_ov", bus.output_valid, 1);
      chk("s3_hold_data", bus.output_data, 32'hB0);
      chk("s3_hold_ready", bus.request_ready, 0);
    end
    bus.output_ready = 1'b1;
    settle();
    chk("s3_resume_ready", bus.request_ready, 4'b0100);
    cyc();
    chk("s3_b1", bus.output_data, 32'hB1);
    chk("s3_b1_ov", bus.output_valid, 1);
    set_data(2, 32'hB2);
    bus.request_last = 4'b0100;
    cyc();
    chk("s3_b2", bus.output_data, 32'hB2);
    chk("s3_b2_last", bus.output_last, 1);
    bus.request_valid = '0;
    cyc();
    chk("s3_drain_ov", bus.output_valid, 0);
    // scenario 4: requester 0 pauses 2 cycles mid-burst, 1 and 2 waiting
    do_reset();
    bus.request_valid = 4'b0111;
    bus.request_last = 4'b0110;
    set_data(0, 32'hC0);
    cyc();
    cyc();
    chk("s4_c0", bus.output_data, 32'hC0);
    chk("s4_c0_src", bus.output_source, 0);
    bus.request_valid = 4'b0110;
    cyc();
    chk("s4_pause_ov", bus.output_valid, 0);
    chk("s4_pause_ready", bus.request_ready, 4'b0001);
    cyc();
    chk("s4_pause2_ready", bus.request_ready, 4'b0001);
    bus.request_valid = 4'b0111;
    set_data(0, 32'hC1);
    cyc();
    chk("s4_c1", bus.output_data, 32'hC1);
    chk("s4_c1_src", bus.output_source, 0);
    set_data(0, 32'hC2);
    bus.request_last = 4'b0111;
    cyc();
    chk("s4_c2", bus.output_data, 32'hC2);
    chk("s4_c2_src", bus.output_source, 0);
    bus.request_valid = 4'b0110;
    cyc();
    chk("s4_next_ready", bus.request_ready, 4'b0010);
    cyc();
    chk("s4_next_src", bus.output_source, 1);
    // scenario 5: reset on second beat restarts from ptr 0
    do_reset();
    bus.request_valid = 4'b0010;
    bus.request_last = 4'b0010;
    cyc();
    cyc();
    chk("s5_pre_src", bus.output_source, 1);
    bus.request_valid = 4'b0100;
    bus.request_last = 4'b0000;
    set_data(2, 32'hD0);
    cyc();
    chk("s5_grant2", bus.request_ready, 4'b0100);
    cyc();
    chk("s5_d0", bus.output_data, 32'hD0);
    chk("s5_d0_src", bus.output_source, 2);
    set_data(2, 32'hD1);
    reset = 1'b1;
    bus.request_valid = 4'b1110;
    cyc();
    reset = 1'b0;
    chk("s5_rst_ov", bus.output_valid, 0);
    chk("s5_rst_ready", bus.request_ready, 0);
    cyc();
    chk("s5_regrant", bus.request_ready, 4'b0010);
    chk("s5_regrant_ov", bus.output_valid, 0);
    // scenario 6: all requesters valid, single-beat bursts
    do_reset();
    bus.request_valid = 4'b1111;
    bus.request_last = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cyc();
      cyc();
      chk("s6_ov", bus.output_valid, 1);
      chk("s6_src", bus.output_source, k % 4);
      chk("s6_data", bus.output_data, 32'h10 + (k % 4));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_arbiter.md
STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 The module SHALL have parameter N, default 4, number of requesters (2..8).
REQ-002 The module SHALL have parameter WIDTH, default 32, data width per beat.
REQ-003 The module SHALL define SRC_W = max(1, clog2(N)) as a local constant.
REQ-004 The module SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The module SHALL have port request_valid, input, N, per-requester beat valid.
REQ-007 The module SHALL have port request_ready, output, N, per-requester beat accept.
REQ-008 The module SHALL have port request_data, input, N*WIDTH, requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 The module SHALL have port request_last, input, N, marking the final beat of a burst.
REQ-010 The module SHALL have port output_ready, input, 1, downstream accept.
REQ-011 The module SHALL have port output_valid, output, 1, registered beat valid.
REQ-012 The module SHALL have ports output_data (WIDTH), output_last (1) and output_source (SRC_W), all outputs, registered copies of the accepted beat and its requester index.

Function
REQ-013 A beat SHALL transfer on the request side when request_valid[i] && request_ready[i], and on the output side when output_valid && output_ready.
REQ-014 The FSM SHALL have two states: IDLE (no grant) and LOCKED (grant register holds one index g).
REQ-015 In IDLE with any request_valid bit set, the FSM SHALL pick the first set index scanning from ptr upward with wrap, register it as g, and enter LOCKED on the next edge; no beat is accepted in IDLE.
REQ-016 In LOCKED, request_ready SHALL be one-hot at bit g, asserted iff !output_valid || output_ready; all other bits SHALL be 0.
REQ-017 A request-side transfer SHALL load output_data, output_last and output_source = g on the same edge and set output_valid.
REQ-018 An output-side transfer with no simultaneous request-side transfer SHALL clear output_valid.
REQ-019 A request-side transfer with request_last = 1 SHALL return the FSM to IDLE and set ptr = (g+1) mod N on that edge.
REQ-020 The grant SHALL be held while request_valid[g] is low mid-burst; there is no timeout or preemption.
REQ-021 While output_valid && !output_ready, output_valid, output_data, output_last and output_source SHALL remain stable.
REQ-022 Latency SHALL be: request_valid rising in IDLE at cycle t gives grant at t+1, first accept at t+1 if the slot is free, and output_valid at t+2.
REQ-023 Within a burst, throughput SHALL be one beat per cycle while output_ready is held high.
REQ-024 Between bursts there SHALL be exactly one idle arbitration cycle, during which no request is accepted and output_valid may still drain.

Reset
REQ-025 On reset the module SHALL set state = IDLE, ptr = 0, g = 0, output_valid = 0 and request_ready = 0; data outputs are don't-care.
REQ-026 Reset mid-burst SHALL discard the burst and any held beat; the following arbitration SHALL restart from ptr = 0.

Structure
REQ-027 The state enum (IDLE, LOCKED) SHALL reside in the shared package stream_pkg.
REQ-028 The round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector, ptr; outputs: index, any).

Verification
REQ-029 Scenario 1: N=4; reset, then request_valid = 4'b0110, one-beat bursts, output_ready = 1. Required: grants 1, 2, 1, 2 with output_source following the same order, and one idle cycle between bursts.
REQ-030 Scenario 2: requester 0 sends a 3-beat burst (data 0xA0, 0xA1, 0xA2, last on the third) while requester 3 is valid. Required: all three beats appear consecutively with source 0, then source 3.
REQ-031 Scenario 3: output_ready = 0 for 5 cycles during a burst. Required: output_valid and output_data stay stable, request_ready[g] = 0 after the first beat, and no beat is lost or duplicated.
REQ-032 Scenario 4: request_valid[g] drops for 2 cycles mid-burst while other requesters are valid. Required: the grant stays at g and the burst completes before any other source appears.
REQ-033 Scenario 5: reset asserted on the second beat of a burst. Required: output_valid = 0 on the next cycle and the next grant goes to the lowest valid index.
REQ-034 Scenario 6: all four requesters continuously valid with one-beat bursts. Required: output_source sequence 0, 1, 2, 3, 0 with no starvation.
